// File: rtl/ysyx_22041207_rd_arbiter_pkg.sv
// Shared types for the IF/MEM read arbiter: FSM state and transaction owner encoding.
package ysyx_22041207_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_22041207_rd_grant.sv
// Combinational IF/MEM grant with a saturating starve counter that lets IF
// through after STARVE_MAX back-to-back MEM wins.
module ysyx_22041207_rd_grant
    import ysyx_22041207_rd_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle_i,
    input  logic if_valid_i,
    input  logic mem_valid_i,
    output logic gnt_if_o,
    output logic gnt_mem_o
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q, starve_d;
    logic          if_forced;

    always_comb begin
        if_forced = (starve_q == CW'(STARVE_MAX));
        gnt_mem_o = idle_i && mem_valid_i && !(if_valid_i && if_forced);
        gnt_if_o  = idle_i && if_valid_i && !gnt_mem_o;
        starve_d  = starve_q;
        // Only counts while IF is actually waiting; any gap in IF demand forgives it.
        if (!if_valid_i || gnt_if_o) begin
            starve_d = '0;
        end else if (gnt_mem_o && !if_forced) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/ysyx_22041207_rd_arbiter.sv
// Two-master (IF, MEM) read arbiter onto a single AXI-style read channel,
// one transaction outstanding, with IF flush support that silently drains a fetch.
module ysyx_22041207_rd_arbiter
    import ysyx_22041207_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_r_valid,
    output logic              if_r_ready,
    input  logic [ADDR_W-1:0] if_r_addr,
    input  logic [7:0]        if_r_size,
    input  logic              if_flush,
    output logic              if_data_valid,
    input  logic              if_data_ready,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_r_valid,
    output logic              mem_r_ready,
    input  logic [ADDR_W-1:0] mem_r_addr,
    input  logic [7:0]        mem_r_size,
    output logic              mem_data_valid,
    input  logic              mem_data_ready,
    output logic [DATA_W-1:0] mem_data,
    output logic              rx_r_valid_i,
    input  logic              rx_r_ready_o,
    output logic [ADDR_W-1:0] rx_r_addr_i,
    output logic [7:0]        rx_r_size_i,
    input  logic              rx_data_valid,
    output logic              rx_data_ready,
    input  logic [DATA_W-1:0] rx_data_read_o
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        size_q, size_d;
    logic              gnt_if, gnt_mem;
    logic              if_own, drop_now;

    ysyx_22041207_rd_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk         (clk),
        .rst_n       (rst_n),
        .idle_i      (state_q == ST_IDLE),
        .if_valid_i  (if_r_valid),
        .mem_valid_i (mem_r_valid),
        .gnt_if_o    (gnt_if),
        .gnt_mem_o   (gnt_mem)
    );

    assign rx_r_valid_i = (state_q == ST_ADDR);
    assign rx_r_addr_i  = addr_q;
    assign rx_r_size_i  = size_q;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        drop_d         = drop_q;
        addr_d         = addr_q;
        size_d         = size_q;
        if_r_ready     = rst_n && gnt_if;
        mem_r_ready    = rst_n && gnt_mem;
        if_data_valid  = 1'b0;
        mem_data_valid = 1'b0;
        if_data        = '0;
        mem_data       = '0;
        rx_data_ready  = 1'b0;
        if_own         = (owner_q == OWN_IF);
        // A flush landing in the same cycle as the data beat must already suppress it.
        drop_now       = drop_q || (if_own && if_flush);

        case (state_q)
            ST_IDLE: begin
                if (gnt_if || gnt_mem) begin
                    state_d = ST_ADDR;
                    owner_d = gnt_if ? OWN_IF : OWN_MEM;
                    addr_d  = gnt_if ? if_r_addr : mem_r_addr;
                    size_d  = gnt_if ? if_r_size : mem_r_size;
                    drop_d  = gnt_if && if_flush;
                end
            end
            ST_ADDR: begin
                drop_d = drop_now;
                if (rx_r_ready_o) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                drop_d = drop_now;
                if (if_own) begin
                    if_data_valid = rx_data_valid && !drop_now;
                    if_data       = rx_data_read_o;
                    rx_data_ready = drop_now || if_data_ready;
                end else begin
                    mem_data_valid = rx_data_valid;
                    mem_data       = rx_data_read_o;
                    rx_data_ready  = mem_data_ready;
                end
                if (rx_data_valid && rx_data_ready) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!rst_n) begin
            if_data_valid  = 1'b0;
            mem_data_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IF;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_rd_arbiter.sv
// Scoreboard bench: requests push expected responses, a negedge monitor pops and compares.
module tb_ysyx_22041207_rd_arbiter;

    localparam int SMAX = 2;

    logic        clk, rst_n;
    logic        if_r_valid, if_r_ready, if_flush;
    logic [63:0] if_r_addr;
    logic [7:0]  if_r_size;
    logic        if_data_valid, if_data_ready;
    logic [63:0] if_data;
    logic        mem_r_valid, mem_r_ready;
    logic [63:0] mem_r_addr;
    logic [7:0]  mem_r_size;
    logic        mem_data_valid, mem_data_ready;
    logic [63:0] mem_data;
    logic        rx_r_valid_i, rx_r_ready_o;
    logic [63:0] rx_r_addr_i;
    logic [7:0]  rx_r_size_i;
    logic        rx_data_valid, rx_data_ready;
    logic [63:0] rx_data_read_o;

    ysyx_22041207_rd_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_r_valid(if_r_valid), .if_r_ready(if_r_ready), .if_r_addr(if_r_addr),
        .if_r_size(if_r_size), .if_flush(if_flush),
        .if_data_valid(if_data_valid), .if_data_ready(if_data_ready), .if_data(if_data),
        .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_addr(mem_r_addr),
        .mem_r_size(mem_r_size),
        .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready), .mem_data(mem_data),
        .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o), .rx_r_addr_i(rx_r_addr_i),
        .rx_r_size_i(rx_r_size_i),
        .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
        .rx_data_read_o(rx_data_read_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: one outstanding transaction, owner 0 = IF, 1 = MEM
    logic [63:0] sb_if[$], sb_mem[$], dn_q[$], addr_log[$];
    logic [71:0] exp_addr[$];
    bit          grant_log[$];
    bit          m_busy, m_owner, m_drop, m_adone;
    int          m_starve;
    bit          if_acc, mem_acc;
    bit          ovr_en;
    logic [63:0] ovr_data;
    int          req_pct;
    bit          mem_hold, flush_en;
    int          n_if_vld;

    function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void reset_model();
        sb_if.delete(); sb_mem.delete(); dn_q.delete(); exp_addr.delete();
        m_busy = 0; m_owner = 0; m_drop = 0; m_adone = 0; m_starve = 0;
    endfunction

    // monitor: response side
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            check("rst_data_valid", {if_data_valid, mem_data_valid}, 0);
        end else begin
            if (if_data_valid) begin
                n_if_vld++;
                check("if_vld_legal", m_busy && !m_owner && !m_drop && !if_flush, 1);
                if (if_data_ready) begin
                    if (sb_if.size() == 0) check("if_resp_unexpected", 1, 0);
                    else begin e = sb_if.pop_front(); check("if_data", if_data, e); end
                end
            end
            if (mem_data_valid) begin
                check("mem_vld_legal", m_busy && m_owner, 1);
                if (mem_data_ready) begin
                    if (sb_mem.size() == 0) check("mem_resp_unexpected", 1, 0);
                    else begin e = sb_mem.pop_front(); check("mem_data", mem_data, e); end
                end
            end
        end
    end

    // one clock: model/request-side checks at negedge+1, returns at posedge+1
    task automatic cycle();
        bit exp_if, exp_mem;
        logic [63:0] d;
        logic [71:0] ea;
        @(negedge clk); #1;
        if_acc = 0; mem_acc = 0;
        if (rst_n) begin
            exp_if  = !m_busy && if_r_valid && (!mem_r_valid || m_starve == SMAX);
            exp_mem = !m_busy && mem_r_valid && !exp_if;
            check("grant", {if_r_ready, mem_r_ready}, {exp_if, exp_mem});
            if (m_busy && !m_owner && (m_drop || if_flush) && rx_data_valid) begin
                check("drop_rx_ready", rx_data_ready, 1);
                check("drop_if_valid", if_data_valid, 0);
            end
            if (m_busy && !m_owner && if_flush && !m_drop) begin
                m_drop = 1;
                if (sb_if.size() > 0) sb_if.delete(sb_if.size() - 1);
            end
            if ((if_r_valid && if_r_ready) || (mem_r_valid && mem_r_ready)) begin
                if_acc  = if_r_valid && if_r_ready;
                mem_acc = !if_acc;
                d = ovr_en ? ovr_data : {$urandom, $urandom};
                ovr_en = 0;
                dn_q.push_back(d);
                m_busy = 1; m_adone = 0; m_owner = mem_acc;
                grant_log.push_back(mem_acc);
                if (if_acc) begin
                    exp_addr.push_back({if_r_addr, if_r_size});
                    m_drop = if_flush;
                    if (!if_flush) sb_if.push_back(d);
                end else begin
                    exp_addr.push_back({mem_r_addr, mem_r_size});
                    m_drop = 0;
                    sb_mem.push_back(d);
                end
            end
            if (!if_r_valid || if_acc) m_starve = 0;
            else if (mem_acc && m_starve < SMAX) m_starve++;
            if (rx_r_valid_i && rx_r_ready_o) begin
                addr_log.push_back(rx_r_addr_i);
                m_adone = 1;
                if (exp_addr.size() == 0) check("rx_addr_unexpected", 1, 0);
                else begin ea = exp_addr.pop_front(); check("rx_addr_size", {rx_r_addr_i, rx_r_size_i}, ea); end
            end
            if (rx_data_valid && rx_data_ready) begin
                if (dn_q.size() > 0) void'(dn_q.pop_front());
                m_busy = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drive_rand();
        rx_r_ready_o   = ($urandom % 3) == 0;
        rx_data_valid  = m_busy && m_adone && (rx_data_valid || ($urandom % 3) == 0);
        rx_data_read_o = (rx_data_valid && dn_q.size() > 0) ? dn_q[0] : {$urandom, $urandom};
        if (if_acc || !if_r_valid) begin
            if_r_valid = ($urandom % 100) < req_pct;
            if_r_addr  = {$urandom, $urandom};
            if_r_size  = 8'($urandom);
        end
        if (mem_acc && mem_hold) begin
            mem_r_addr = mem_r_addr + 64'h10;
        end else if (mem_acc || !mem_r_valid) begin
            mem_r_valid = ($urandom % 100) < req_pct;
            mem_r_addr  = {$urandom, $urandom};
            mem_r_size  = 8'($urandom);
        end
        if_data_ready  = ($urandom % 4) != 0;
        mem_data_ready = ($urandom % 4) != 0;
        if_flush       = flush_en && !rx_data_valid && ($urandom % 8) == 0;
    endtask

    task automatic quiet_inputs();
        if_r_valid = 0; mem_r_valid = 0; if_flush = 0;
        rx_r_ready_o = 0; rx_data_valid = 0; rx_data_read_o = '0;
        if_data_ready = 1; mem_data_ready = 1;
    endtask

    task automatic drain();
        req_pct = 0; mem_hold = 0; flush_en = 0;
        for (int k = 0; k < 400; k++) begin
            if (!if_r_valid && !mem_r_valid && !m_busy) break;
            cycle();
            drive_rand();
        end
        check("drain_idle", {if_r_valid, mem_r_valid, m_busy}, 0);
        quiet_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 0; ovr_en = 0; ovr_data = '0; n_if_vld = 0;
        req_pct = 0; mem_hold = 0; flush_en = 0;
        if_r_addr = '0; if_r_size = '0; mem_r_addr = '0; mem_r_size = '0;
        if_acc = 0; mem_acc = 0;
        quiet_inputs();
        reset_model();
        repeat (3) cycle();
        check("rst_rx_r", {rx_r_valid_i, rx_r_addr_i, rx_r_size_i}, 0);
        rst_n = 1;
        cycle(); cycle();

        // IF alone, fixed latencies
        begin
            int n0;
            n0 = n_if_vld;
            if_r_valid = 1; if_r_addr = 64'h8000_0000; if_r_size = 8'h0F;
            ovr_en = 1; ovr_data = 64'h0000_0013_0010_0093;
            cycle();
            check("if_alone_acc", if_acc, 1);
            if_r_valid = 0; rx_r_ready_o = 1;
            cycle();
            rx_r_ready_o = 0;
            cycle();
            rx_data_valid = 1; rx_data_read_o = 64'h0000_0013_0010_0093;
            cycle();
            rx_data_valid = 0;
            cycle(); cycle();
            check("if_alone_vld_cycles", n_if_vld - n0, 1);
        end

        // simultaneous IF and MEM: MEM first
        addr_log.delete();
        if_r_valid = 1; if_r_addr = 64'h8000_0004; if_r_size = 8'h0F;
        mem_r_valid = 1; mem_r_addr = 64'h8000_1000; mem_r_size = 8'h07;
        drain();
        check("order_len", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            check("order_first", addr_log[0], 64'h8000_1000);
            check("order_second", addr_log[1], 64'h8000_0004);
        end

        // MEM held continuously: IF forced in after SMAX MEM grants, twice
        grant_log.delete();
        req_pct = 0; mem_hold = 1; flush_en = 0;
        if_r_valid = 1; if_r_addr = 64'h8000_0010; if_r_size = 8'h0F;
        mem_r_valid = 1; mem_r_addr = 64'h9000_0000; mem_r_size = 8'h07;
        for (int k = 0; k < 300 && grant_log.size() < 3; k++) begin cycle(); drive_rand(); end
        if_r_valid = 1; if_r_addr = 64'h8000_0020; if_r_size = 8'h0F;
        for (int k = 0; k < 300 && grant_log.size() < 6; k++) begin cycle(); drive_rand(); end
        check("starve_len", grant_log.size() >= 6, 1);
        if (grant_log.size() >= 6)
            check("starve_seq", {grant_log[0], grant_log[1], grant_log[2],
                                 grant_log[3], grant_log[4], grant_log[5]}, 6'b110110);
        drain();

        // flush during DATA, then immediate new fetch
        if_r_valid = 1; if_r_addr = 64'h8000_0008; if_r_size = 8'h0F; if_data_ready = 0;
        cycle();
        if_r_valid = 0; rx_r_ready_o = 1;
        cycle();
        rx_r_ready_o = 0; if_flush = 1;
        cycle();
        if_flush = 0; rx_data_valid = 1; rx_data_read_o = 64'hDEAD_BEEF_0BAD_F00D;
        check("flush_rx_ready", rx_data_ready, 1);
        check("flush_if_valid", if_data_valid, 0);
        cycle();
        rx_data_valid = 0; if_data_ready = 1;
        if_r_valid = 1; if_r_addr = 64'h8000_0100;
        cycle();
        check("flush_reaccept", if_acc, 1);
        drain();

        // reset while in ADDR
        if_r_valid = 1; if_r_addr = 64'h8000_0200; if_r_size = 8'h0F;
        cycle();
        if_r_valid = 0;
        cycle();
        check("rst_mid_pre", rx_r_valid_i, 1);
        rst_n = 0;
        cycle();
        rst_n = 1;
        reset_model();
        check("rst_mid_rx", {rx_r_valid_i, rx_r_addr_i}, 0);
        rx_data_valid = 1; rx_data_read_o = 64'h1234_5678_9ABC_DEF0;
        repeat (3) begin
            check("rst_mid_nofwd", {if_data_valid, mem_data_valid, rx_data_ready}, 0);
            cycle();
        end
        rx_data_valid = 0;
        if_r_valid = 1; if_r_addr = 64'h8000_0240;
        cycle();
        check("rst_mid_reaccept", if_acc, 1);
        drain();

        // downstream address stall
        if_r_valid = 1; if_r_addr = 64'h8000_0300; if_r_size = 8'h0F;
        cycle();
        if_r_addr = 64'h8000_0400; mem_r_valid = 1; mem_r_addr = 64'h9000_1000;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("stall_rx", {rx_r_valid_i, rx_r_addr_i, rx_r_size_i}, {1'b1, 64'h8000_0300, 8'h0F});
            check("stall_ready", {if_r_ready, mem_r_ready}, 0);
        end
        drain();

        // randomized traffic
        req_pct = 40; flush_en = 1; mem_hold = 0;
        for (int k = 0; k < 3000; k++) begin cycle(); drive_rand(); end
        drain();
        cycle(); cycle();
        check("queues_empty", sb_if.size() + sb_mem.size() + dn_q.size() + exp_addr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_rd_arbiter.md
YSYX_22041207_RD_ARBITER -- requirements
Module: ysyx_22041207_rd_arbiter

Interface
REQ-001 Parameter ADDR_W, 64, address width of all ports.
REQ-002 Parameter DATA_W, 64, read data width of all ports.
REQ-003 Parameter STARVE_MAX, 2, number of consecutive MEM grants with IF waiting before IF is forced.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-006 if_r_valid / if_r_ready  in / out  1 / 1  IF request handshake.
REQ-007 if_r_addr / if_r_size  in  ADDR_W / 8  IF request address and byte-strobe size.
REQ-008 if_flush  in  1  IF discards its outstanding fetch (pc redirect).
REQ-009 if_data_valid / if_data_ready / if_data  out / in / out  1 / 1 / DATA_W  IF response channel.
REQ-010 mem_r_valid / mem_r_ready / mem_r_addr / mem_r_size  in / out / in / in  1 / 1 / ADDR_W / 8  MEM request channel.
REQ-011 mem_data_valid / mem_data_ready / mem_data  out / in / out  1 / 1 / DATA_W  MEM response channel.
REQ-012 rx_r_valid_i / rx_r_ready_o / rx_r_addr_i / rx_r_size_i  out / in / out / out  1 / 1 / ADDR_W / 8  shared AXI read address channel.
REQ-013 rx_data_valid / rx_data_ready / rx_data_read_o  in / out / in  1 / 1 / DATA_W  shared AXI read data channel.

Function
REQ-014 FSM states IDLE, ADDR, DATA; one downstream transaction outstanding at most.
REQ-015 IDLE: grant computed combinationally; granted requester's *_r_ready = 1, other = 0; no request -> both 0.
REQ-016 Priority: MEM over IF, except IF wins when starve counter == STARVE_MAX.
REQ-017 Starve counter: +1 on each MEM grant while if_r_valid = 1; cleared on IF grant or when if_r_valid = 0; saturates at STARVE_MAX.
REQ-018 Request accept (valid && ready in IDLE): latch owner, addr, size; next cycle state ADDR, rx_r_valid_i = 1.
REQ-019 ADDR: rx_r_addr_i/rx_r_size_i hold latched values, rx_r_valid_i held 1 until rx_r_ready_o; on handshake -> DATA, rx_r_valid_i = 0 next cycle.
REQ-020 DATA: rx_data_valid and rx_data_read_o forwarded combinationally to owner only; owner's data_ready forwarded to rx_data_ready; non-owner data_valid = 0.
REQ-021 On rx_data_valid && rx_data_ready -> IDLE; earliest next accept is the following cycle (min 3 cycles accept-to-accept).
REQ-022 if_flush while IF owns ADDR or DATA: set drop flag; transaction completes downstream, rx_data_ready forced 1 in DATA, if_data_valid forced 0, data discarded.
REQ-023 if_flush in the same cycle as IF accept: request accepted, drop flag set immediately.
REQ-024 if_flush with IF not owner, or in IDLE: no effect; MEM transactions never dropped.
REQ-025 Drop flag cleared on return to IDLE.
REQ-026 Size/address passed unmodified; no alignment or range checks.

Reset
REQ-027 rst_n = 0 at posedge: state IDLE, owner IF, drop 0, starve counter 0, rx_r_valid_i 0, rx_r_addr_i 0, rx_r_size_i 0.
REQ-028 Reset mid-transaction abandons it; no response forwarded after reset; if/mem data_valid = 0 during reset.

Structure
REQ-029 Shared package holds FSM state enum (IDLE/ADDR/DATA) and owner encoding (OWN_IF = 0, OWN_MEM = 1).
REQ-030 Single flat module; grant/starve logic MAY be sub-module ysyx_22041207_rd_grant (combinational grant + starve counter).

Verification
REQ-031 IF alone, addr 0x80000000, size 0x0F, rx_r_ready_o 1 cycle later, data 0x00000013_00100093 two cycles later -> if_data = same value, if_data_valid 1 cycle, mem_data_valid never 1.
REQ-032 IF and MEM valid same cycle (0x80000004 / 0x80001000) -> MEM granted first, IF granted in next IDLE; rx_r_addr_i sequence 0x80001000 then 0x80000004.
REQ-033 MEM held valid continuously, IF valid -> after 2 MEM grants, IF granted third; starve counter back to 0.
REQ-034 IF fetch 0x80000008 in DATA, if_flush pulsed, rx_data_valid arrives -> rx_data_ready 1, if_data_valid 0, FSM IDLE next cycle, new IF 0x80000100 accepted.
REQ-035 rst_n low during ADDR with rx_r_valid_i = 1 -> next cycle rx_r_valid_i 0, state IDLE, subsequent rx_data_valid not forwarded.
REQ-036 rx_r_ready_o stalled 5 cycles -> rx_r_valid_i, rx_r_addr_i stable all 5 cycles; both *_r_ready 0.
